// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-port memory arbiter.
// Port indices are zero-based, so bit k of a grant vector belongs to PORT k.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0] PORT_CPU = 2'd0;
  localparam logic [1:0] PORT_FIR = 2'd1;
  localparam logic [1:0] PORT_MM  = 2'd2;
  localparam logic [1:0] PORT_QS  = 2'd3;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = PORT_CPU;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three requesters. ptr_i is the slot
// served last; the search starts at the slot after it and wraps.
module rr_pick3 (
  input  logic [2:0] pending_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] win_o,
  output logic       valid_o
);

  always_comb begin
    win_o = 3'b000;
    case (ptr_i)
      2'd0: begin
        if      (pending_i[1]) win_o = 3'b010;
        else if (pending_i[2]) win_o = 3'b100;
        else if (pending_i[0]) win_o = 3'b001;
      end
      2'd1: begin
        if      (pending_i[2]) win_o = 3'b100;
        else if (pending_i[0]) win_o = 3'b001;
        else if (pending_i[1]) win_o = 3'b010;
      end
      default: begin
        if      (pending_i[0]) win_o = 3'b001;
        else if (pending_i[1]) win_o = 3'b010;
        else if (pending_i[2]) win_o = 3'b100;
      end
    endcase
  end

  assign valid_o = |pending_i;

endmodule

// File: rtl/mem_arbiter_rr.sv
// Serialises CPU and three DMA requesters onto one memory port. The CPU wins
// unless it has hogged CPU_MAX grants while a DMA waits; DMAs rotate fairly.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CPU_MAX = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [ADDR_W-1:0] addr_3,
  input  logic [ADDR_W-1:0] addr_4,
  input  logic              rw_1,
  input  logic              rw_2,
  input  logic              rw_3,
  input  logic              rw_4,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  input  logic              in_valid_4,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  input  logic [DATA_W-1:0] in_data_4,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic              out_valid_3,
  output logic              out_valid_4,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [DATA_W-1:0] out_data_3,
  output logic [DATA_W-1:0] out_data_4,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        grant,
  output logic              err
);

  state_t            state_q;
  logic [3:0]        grant_q;
  logic [3:0]        outValid_q;
  logic [DATA_W-1:0] outData_q [4];
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic              err_q;
  logic [3:0]        cpuCnt_q;
  logic [1:0]        rrPtr_q;
  logic [7:0]        tmoCnt_q;

  logic [2:0]        dmaPend;
  logic [2:0]        dmaWin;
  logic              dmaValid;
  logic              cpuWins;
  logic [3:0]        grant_d;
  logic [1:0]        winIdx;
  logic [1:0]        ownIdx;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d;
  logic [DATA_W-1:0] wdata_d;

  assign dmaPend = {in_valid_4, in_valid_3, in_valid_2};

  // rrPtr_q holds a port index (FIR..QS); the picker works on DMA slots 0..2.
  rr_pick3 uPick (
    .pending_i (dmaPend),
    .ptr_i     (rrPtr_q - PORT_FIR),
    .win_o     (dmaWin),
    .valid_o   (dmaValid)
  );

  always_comb begin
    cpuWins = in_valid_1 && ((cpuCnt_q < 4'(CPU_MAX)) || !dmaValid);
    grant_d = cpuWins ? 4'b0001 : {dmaWin, 1'b0};
    winIdx  = onehot4_to_idx(grant_d);
    addr_d  = addr_1;
    we_d    = rw_1;
    wdata_d = in_data_1;
    case (winIdx)
      PORT_FIR: begin addr_d = addr_2; we_d = rw_2; wdata_d = in_data_2; end
      PORT_MM:  begin addr_d = addr_3; we_d = rw_3; wdata_d = in_data_3; end
      PORT_QS:  begin addr_d = addr_4; we_d = rw_4; wdata_d = in_data_4; end
      default:  ;
    endcase
  end

  assign ownIdx = onehot4_to_idx(grant_q);

  // The counter is allowed to reach zero and still wait one more cycle, so an
  // abort completes TIMEOUT+1 cycles after mem_req rises and a late ack wins.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      outValid_q <= '0;
      for (int k = 0; k < 4; k++) outData_q[k] <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      err_q      <= 1'b0;
      cpuCnt_q   <= '0;
      rrPtr_q    <= PORT_QS;
      tmoCnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d != 4'b0000) begin
            grant_q    <= grant_d;
            memAddr_q  <= addr_d;
            memWe_q    <= we_d;
            memWdata_q <= wdata_d;
            memReq_q   <= 1'b1;
            tmoCnt_q   <= 8'(TIMEOUT);
            state_q    <= REQ;
            if (cpuWins) begin
              if (cpuCnt_q != 4'hF) cpuCnt_q <= cpuCnt_q + 4'd1;
            end else begin
              cpuCnt_q <= '0;
              rrPtr_q  <= winIdx;
            end
          end
        end
        REQ: begin
          if (mem_ack || tmoCnt_q == 8'd0) begin
            memReq_q          <= 1'b0;
            outValid_q        <= grant_q;
            err_q             <= !mem_ack;
            outData_q[ownIdx] <= mem_ack ? mem_rdata : DATA_W'(ABORT_DATA);
            state_q           <= DONE;
          end else begin
            tmoCnt_q <= tmoCnt_q - 8'd1;
          end
        end
        DONE: begin
          outValid_q <= '0;
          err_q      <= 1'b0;
          grant_q    <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_1 = outValid_q[0];
  assign out_valid_2 = outValid_q[1];
  assign out_valid_3 = outValid_q[2];
  assign out_valid_4 = outValid_q[3];
  assign out_data_1  = outData_q[0];
  assign out_data_2  = outData_q[1];
  assign out_data_3  = outData_q[2];
  assign out_data_4  = outData_q[3];
  assign mem_req     = memReq_q;
  assign mem_we      = memWe_q;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign grant       = grant_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a table of single transactions against a
// scripted memory, then grant-order and reset sequences.
module tb_mem_arbiter_rr;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int CPU_MAX = 4;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [AW-1:0] addr    [4];
  logic          rw      [4];
  logic          inValid [4];
  logic [DW-1:0] inData  [4];
  wire  [3:0]    outValidV;
  wire  [DW-1:0] od      [4];
  wire           memReq;
  wire           memWe;
  wire  [AW-1:0] memAddr;
  wire  [DW-1:0] memWdata;
  logic          memAck;
  logic [DW-1:0] memRdata;
  wire  [3:0]    grant;
  wire           err;

  mem_arbiter_rr #(
    .ADDR_W(AW), .DATA_W(DW), .CPU_MAX(CPU_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i    (clock),
    .wb_rst_i    (reset),
    .addr_1      (addr[0]),
    .addr_2      (addr[1]),
    .addr_3      (addr[2]),
    .addr_4      (addr[3]),
    .rw_1        (rw[0]),
    .rw_2        (rw[1]),
    .rw_3        (rw[2]),
    .rw_4        (rw[3]),
    .in_valid_1  (inValid[0]),
    .in_valid_2  (inValid[1]),
    .in_valid_3  (inValid[2]),
    .in_valid_4  (inValid[3]),
    .in_data_1   (inData[0]),
    .in_data_2   (inData[1]),
    .in_data_3   (inData[2]),
    .in_data_4   (inData[3]),
    .out_valid_1 (outValidV[0]),
    .out_valid_2 (outValidV[1]),
    .out_valid_3 (outValidV[2]),
    .out_valid_4 (outValidV[3]),
    .out_data_1  (od[0]),
    .out_data_2  (od[1]),
    .out_data_3  (od[2]),
    .out_data_4  (od[3]),
    .mem_req     (memReq),
    .mem_we      (memWe),
    .mem_addr    (memAddr),
    .mem_wdata   (memWdata),
    .mem_ack     (memAck),
    .mem_rdata   (memRdata),
    .grant       (grant),
    .err         (err)
  );

  typedef struct {
    int          port;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackAt;
    logic        dropEarly;
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] expOut [4];
  int            checks   = 0;
  int            failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  // ackAt counts REQ cycles from the one where mem_req rises; -1 never acks.
  task automatic applyStimulus(input int idx, input vec_t v);
    int         reqCycles;
    int         lat;
    bit         done;
    bit         stable;
    logic [3:0] oneHot;
    oneHot = 4'b0001 << v.port;
    addr[v.port]    = v.addr;
    rw[v.port]      = v.rw;
    inData[v.port]  = v.wdata;
    inValid[v.port] = 1'b1;
    waitCycle();
    checkOutput($sformatf("v%0d_mem_req", idx), 64'(memReq), 64'd1);
    checkOutput($sformatf("v%0d_grant", idx), 64'(grant), 64'(oneHot));
    checkOutput($sformatf("v%0d_mem_addr", idx), 64'(memAddr), 64'(v.addr));
    checkOutput($sformatf("v%0d_mem_we", idx), 64'(memWe), 64'(v.rw));
    if (v.dropEarly) inValid[v.port] = 1'b0;
    reqCycles = 0;
    lat       = 0;
    done      = 0;
    stable    = 1;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (memReq) begin
        if (memAddr !== v.addr || memWe !== v.rw || memWdata !== v.wdata || grant !== oneHot)
          stable = 0;
        if (reqCycles == v.ackAt) begin
          memAck   = 1'b1;
          memRdata = v.rdata;
        end
        reqCycles++;
      end
      waitCycle();
      memAck = 1'b0;
      if (outValidV != 4'b0000) begin
        done = 1;
        lat  = c;
      end
    end
    checkOutput($sformatf("v%0d_completed", idx), 64'(done), 64'd1);
    checkOutput($sformatf("v%0d_mem_stable", idx), 64'(stable), 64'd1);
    checkOutput($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.expLat));
    checkOutput($sformatf("v%0d_out_valid", idx), 64'(outValidV), 64'(oneHot));
    checkOutput($sformatf("v%0d_err", idx), 64'(err), 64'(v.expErr));
    checkOutput($sformatf("v%0d_req_low_done", idx), 64'(memReq), 64'd0);
    expOut[v.port] = v.expData;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("v%0d_out_data_%0d", idx, k + 1), 64'(od[k]), 64'(expOut[k]));
    inValid[v.port] = 1'b0;
    waitCycle();
    checkOutput($sformatf("v%0d_idle_valid", idx), 64'(outValidV), 64'd0);
    checkOutput($sformatf("v%0d_idle_err", idx), 64'(err), 64'd0);
    checkOutput($sformatf("v%0d_idle_grant", idx), 64'(grant), 64'd0);
    memAck   = 1'b1;
    memRdata = 32'h0BAD_0BAD;
    waitCycle();
    memAck = 1'b0;
    checkOutput($sformatf("v%0d_stray_ack_req", idx), 64'(memReq), 64'd0);
    checkOutput($sformatf("v%0d_stray_ack_valid", idx), 64'(outValidV), 64'd0);
    checkOutput($sformatf("v%0d_stray_ack_data", idx), 64'(od[v.port]), 64'(v.expData));
  endtask

  // Requesters in mask hold in_valid; memory acks in the first REQ cycle.
  task automatic runOrder(input string tag, input logic [3:0] mask, input int expPorts [10], input int n);
    int got;
    got = 0;
    for (int k = 0; k < 4; k++) inValid[k] = mask[k];
    for (int c = 0; c < 3 * n + 20 && got < n; c++) begin
      if (memReq) begin
        checkOutput($sformatf("%s_grant_%0d", tag, got), 64'(grant), 64'(4'b0001 << expPorts[got]));
        got++;
        memAck   = 1'b1;
        memRdata = 32'h0000_1000 + 32'(got);
      end else begin
        memAck = 1'b0;
      end
      waitCycle();
    end
    memAck = 1'b0;
    for (int k = 0; k < 4; k++) inValid[k] = 1'b0;
    checkOutput($sformatf("%s_count", tag), 64'(got), 64'(n));
    waitCycle();
    waitCycle();
    checkOutput($sformatf("%s_idle_req", tag), 64'(memReq), 64'd0);
  endtask

  task automatic resetMidReq(input string tag, input int port);
    addr[port]    = 32'h4000_0000 + 32'(port);
    rw[port]      = 1'b1;
    inData[port]  = 32'h7777_0000;
    inValid[port] = 1'b1;
    waitCycle();
    checkOutput($sformatf("%s_pre_req", tag), 64'(memReq), 64'd1);
    waitCycle();
    #2 reset = 1'b1;
    #1;
    checkOutput($sformatf("%s_async_req", tag), 64'(memReq), 64'd0);
    checkOutput($sformatf("%s_async_grant", tag), 64'(grant), 64'd0);
    checkOutput($sformatf("%s_async_valid", tag), 64'(outValidV), 64'd0);
    checkOutput($sformatf("%s_async_addr", tag), 64'(memAddr), 64'd0);
    inValid[port] = 1'b0;
    waitCycle();
    #3 reset = 1'b0;
    waitCycle();
    for (int k = 0; k < 4; k++) expOut[k] = '0;
    checkOutput($sformatf("%s_post_data", tag), 64'(od[0] | od[1] | od[2] | od[3]), 64'd0);
    checkOutput($sformatf("%s_post_valid", tag), 64'(outValidV), 64'd0);
  endtask

  initial begin
    int orderA [10];
    int orderB [10];

    vecs[0] = '{port:0, rw:1'b0, addr:32'h3800_0010, wdata:32'h0, rdata:32'h1234_5678,
                ackAt:0, dropEarly:1'b0, expData:32'h1234_5678, expErr:1'b0, expLat:1};
    vecs[1] = '{port:1, rw:1'b0, addr:32'h1000_0004, wdata:32'h0, rdata:32'h0,
                ackAt:-1, dropEarly:1'b0, expData:32'hDEAD_BEEF, expErr:1'b1, expLat:9};
    vecs[2] = '{port:1, rw:1'b0, addr:32'h1000_0008, wdata:32'h0, rdata:32'hA5A5_0001,
                ackAt:2, dropEarly:1'b1, expData:32'hA5A5_0001, expErr:1'b0, expLat:3};
    vecs[3] = '{port:3, rw:1'b1, addr:32'h2000_0100, wdata:32'hCAFE_F00D, rdata:32'h5555_AAAA,
                ackAt:8, dropEarly:1'b0, expData:32'h5555_AAAA, expErr:1'b0, expLat:9};
    vecs[4] = '{port:2, rw:1'b1, addr:32'h3000_0040, wdata:32'h0BEE_F00D, rdata:32'h1111_2222,
                ackAt:7, dropEarly:1'b0, expData:32'h1111_2222, expErr:1'b0, expLat:8};
    vecs[5] = '{port:0, rw:1'b1, addr:32'h3800_0020, wdata:32'h8765_4321, rdata:32'h0000_0042,
                ackAt:1, dropEarly:1'b0, expData:32'h0000_0042, expErr:1'b0, expLat:2};
    orderA = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
    orderB = '{1, 2, 3, 1, 2, 3, 0, 0, 0, 0};

    reset    = 1'b1;
    memAck   = 1'b0;
    memRdata = '0;
    for (int k = 0; k < 4; k++) begin
      addr[k]    = '0;
      rw[k]      = 1'b0;
      inValid[k] = 1'b0;
      inData[k]  = '0;
      expOut[k]  = '0;
    end
    waitCycle();
    waitCycle();
    #3 reset = 1'b0;
    waitCycle();
    checkOutput("rst_mem_req", 64'(memReq), 64'd0);
    checkOutput("rst_mem_we", 64'(memWe), 64'd0);
    checkOutput("rst_mem_addr", 64'(memAddr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(memWdata), 64'd0);
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_out_valid", 64'(outValidV), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_out_data", 64'(od[0] | od[1] | od[2] | od[3]), 64'd0);

    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    resetMidReq("rstA", 0);
    runOrder("cpuMm", 4'b0101, orderA, 10);

    resetMidReq("rstB", 1);
    runOrder("dmaRr", 4'b1110, orderB, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Four-requester arbiter that serialises accesses from the CPU Wishbone path and the three accelerator DMAs (FIR, matmul, quicksort) onto the single user-area memory port. The policy is weighted priority:
- The CPU normally wins.
- A starvation guard forces a DMA grant after a bounded number of consecutive CPU grants.
- DMAs are served round-robin among themselves.

The block sits between the four `addr_k/rw_k/in_valid_k` request bundles and the memory (BRAM/SDRAM) controller, and adds per-transaction timeout protection.

## Interface
Parameters:
- `ADDR_W`, 32, address width of every port.
- `DATA_W`, 32, data width of every port.
- `CPU_MAX`, 4, consecutive CPU grants allowed while any DMA is pending (range 1..15).
- `TIMEOUT`, 255, cycles spent in REQ without `mem_ack` before abort (range 1..255).

Ports (k = 1..4; 1 = CPU, 2 = FIR DMA, 3 = MM DMA, 4 = QS DMA):
- `wb_clk_i`  in  1  sole clock, rising edge.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `addr_k`  in  ADDR_W  request address, held stable while `in_valid_k` is high.
- `rw_k`  in  1  1 = write, 0 = read.
- `in_valid_k`  in  1  level request, held until `out_valid_k` is seen.
- `in_data_k`  in  DATA_W  write data.
- `out_valid_k`  out  1  one-cycle completion pulse.
- `out_data_k`  out  DATA_W  read data, valid with `out_valid_k`.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_ack`  in  1  memory completion, single-cycle.
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`.
- `grant`  out  4  one-hot owner; bit k-1 corresponds to port k; 0 in IDLE.
- `err`  out  1  one-cycle pulse with `out_valid_k` on a timeout abort.

## Operation
States: IDLE, REQ, DONE.

IDLE:
- Evaluate the `in_valid` vector combinationally.
- When any request is present, register the winner into `grant`, latch its addr/rw/wdata into the `mem_*` registers, load the timeout counter with TIMEOUT, and go to REQ.
- With no request, stay in IDLE.

Winner selection, in order:
1. Port 1 wins if `in_valid_1` and (`cpu_cnt` < CPU_MAX or no DMA is pending).
2. Otherwise the first pending DMA found scanning from `rr_ptr`+1 through 2, 3, 4 with wrap-around.

Counter and pointer updates:
- `cpu_cnt` (4 bits) increments on each CPU grant and saturates at 15.
- `cpu_cnt` clears on any DMA grant.
- `rr_ptr` is set to the granted DMA index; it is unchanged on CPU grants.

REQ:
- `mem_req` = 1 and the `mem_*` outputs are stable.
- On `mem_ack`: capture `mem_rdata` into the granted port's `out_data`, go to DONE.
- Otherwise decrement the counter. Reaching 0 without ack aborts: `out_data` = 32'hDEAD_BEEF, `err` flag set, go to DONE.

DONE:
- `mem_req` = 0.
- Pulse `out_valid_k` for the granted port, and pulse `err` if the abort flag is set.
- Clear `grant` and go to IDLE.

Boundary rules:
- Other ports' `out_data` hold their last value; `out_valid` of non-granted ports stays 0.
- `in_valid_k` dropping mid-transaction is a protocol violation. The transaction still completes and `out_valid_k` still pulses.
- `mem_ack` arriving in the same cycle the counter reaches 0 counts as success.
- `mem_ack` arriving outside REQ is ignored.
- Reset mid-transaction: all outputs go to reset values immediately, with no completion pulse. The memory side must tolerate a dropped `mem_req`.

## Timing
Reset values:
- State IDLE.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, all `out_valid_k`, all `out_data_k`, `grant`, `err` = 0.
- `cpu_cnt` = 0.
- `rr_ptr` = 4, so the first DMA grant goes to port 2.

Registering:
- All outputs are registered.
- `in_valid` and `mem_ack` are sampled only at clock edges.

Cycle sequence:
- A request high in IDLE cycle N gives `mem_req` = 1 in N+1.
- `mem_ack` in cycle M gives `out_valid_k` in M+1 and IDLE in M+2.
- A zero-wait memory (ack in N+1) therefore sustains one transfer per 3 cycles.
- Requesters deassert `in_valid` in the cycle after seeing `out_valid`. The arbiter is in IDLE that cycle and sees the deassertion, so there is no double grant.
- Timeout: `out_valid_k` with `err` arrives TIMEOUT+1 cycles after `mem_req` rises.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum {IDLE, REQ, DONE};
  - port index constants `PORT_CPU` = 0 … `PORT_QS` = 3;
  - the abort data constant 32'hDEAD_BEEF.
- Sub-module `rr_pick3` is combinational. Inputs: 3-bit pending vector and 2-bit pointer. Outputs: one-hot winner and a valid flag. It is reused by future DMA muxes.

## Test plan
- CPU only, with memory acking 1 cycle after `mem_req`: read of 0x3800_0010 returns `mem_rdata` 0x1234_5678 on `out_data_1`, `out_valid_1` one cycle, 3 cycles per transfer.
- CPU and port 3 continuously requesting, CPU_MAX = 4: grant order 1, 1, 1, 1, 3, 1, 1, 1, 1, 3.
- Ports 2, 3, 4 continuously requesting, CPU idle: grant order 2, 3, 4, 2, 3, 4.
- Memory never acks, TIMEOUT = 8: `out_valid_2` and `err` pulse 9 cycles after `mem_req` rises, with `out_data_2` = 0xDEAD_BEEF; the next request proceeds normally.
- Reset asserted while in REQ: `mem_req`, `grant` and `out_valid` drop to 0 asynchronously; after release the first DMA grant goes to port 2 and `cpu_cnt` is 0.
- Write from port 4 with `mem_ack` in the same cycle the counter reaches 0: treated as success, `err` = 0, `mem_we` = 1 with the latched address and data throughout REQ.
